// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (clk, rst, rx -> uart_data, uart_received, frame_error, busy)
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_received,
  output logic       frame_error,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  logic          sync_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          rcv_q, rcv_d, ferr_q, ferr_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    rcv_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        state_d = rx_s_q ? S_IDLE : S_START;
      end
      S_START: if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        data_d = rx_s_q ? shift_q : data_q;
        rcv_d = rx_s_q;
        ferr_d = !rx_s_q;
        state_d = rx_s_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = '0;
        state_d = rx_s_q ? S_IDLE : S_WAIT;
      end
      default: begin
        cnt_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      rcv_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= rx;
      rx_s_q <= sync_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      rcv_q <= rcv_d;
      ferr_q <= ferr_d;
    end
  end
  assign uart_data = data_q;
  assign uart_received = rcv_q;
  assign frame_error = ferr_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at CLKS_PER_BIT = 8 (80 time-unit bit period)
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] uart_data;
  logic       uart_received, frame_error, busy;
  int         checks = 0, errors = 0;
  int         rcv_cnt = 0, ferr_cnt = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] log_q[$];
  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .uart_data(uart_data),
    .uart_received(uart_received), .frame_error(frame_error), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (uart_received) begin
      rcv_cnt <= rcv_cnt + 1;
      log_q.push_back(uart_data);
    end
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
    if (busy) busy_seen <= 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per);
    end
    rx = stop;
    #(per);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n, r0, f0, q0, hits;
    logic [7:0] d0;
    cycles(3);
    chk("rst_data", 32'(uart_data), 32'h00);
    chk("rst_rcv", 32'(uart_received), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cycles(5);
    r0 = rcv_cnt; f0 = ferr_cnt; n = 0;
    fork
      send_frame(8'hA5, 1'b1, 80);
      begin
        while (n < 200) begin
          @(posedge clk);
          #1;
          n++;
          if (uart_received) break;
        end
      end
    join
    cycles(20);
    chk("a5_latency", 32'(n), 32'd79);
    chk("a5_data", 32'(uart_data), 32'hA5);
    chk("a5_strobes", 32'(rcv_cnt - r0), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
    r0 = rcv_cnt; f0 = ferr_cnt; q0 = log_q.size();
    send_frame(8'h00, 1'b1, 80);
    send_frame(8'hFF, 1'b1, 80);
    send_frame(8'h3C, 1'b1, 80);
    cycles(20);
    chk("b2b_strobes", 32'(rcv_cnt - r0), 32'd3);
    chk("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
    if (log_q.size() >= q0 + 3) begin
      chk("b2b_d0", 32'(log_q[q0]), 32'h00);
      chk("b2b_d1", 32'(log_q[q0+1]), 32'hFF);
      chk("b2b_d2", 32'(log_q[q0+2]), 32'h3C);
    end
    r0 = rcv_cnt; f0 = ferr_cnt; d0 = uart_data;
    busy_seen = 1'b0;
    rx = 1'b0;
    #20;
    rx = 1'b1;
    cycles(20);
    chk("glitch_busy_seen", 32'(busy_seen), 32'h1);
    chk("glitch_busy_now", 32'(busy), 32'h0);
    chk("glitch_strobes", 32'(rcv_cnt - r0), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("glitch_data", 32'(uart_data), 32'(d0));
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    r0 = rcv_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 80);
    #400;
    chk("ferr_wait_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    cycles(10);
    chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_strobe", 32'(rcv_cnt - r0), 32'd0);
    chk("ferr_data_held", 32'(uart_data), 32'h00);
    send_frame(8'h12, 1'b1, 80);
    cycles(20);
    chk("ferr_next_data", 32'(uart_data), 32'h12);
    chk("ferr_next_strobes", 32'(rcv_cnt - r0), 32'd1);
    chk("ferr_total", 32'(ferr_cnt - f0), 32'd1);
    q0 = log_q.size();
    fork
      send_frame(8'hC3, 1'b1, 80);
      begin
        #440;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycles(1);
        chk("midrst_data", 32'(uart_data), 32'h00);
        chk("midrst_rcv", 32'(uart_received), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
      end
    join
    cycles(150);
    hits = 0;
    for (int i = q0; i < log_q.size(); i++) if (log_q[i] == 8'hC3) hits++;
    chk("midrst_no_c3", 32'(hits), 32'd0);
    r0 = rcv_cnt;
    send_frame(8'h7E, 1'b1, 80);
    cycles(20);
    chk("midrst_next_data", 32'(uart_data), 32'h7E);
    chk("midrst_next_strobes", 32'(rcv_cnt - r0), 32'd1);
    r0 = rcv_cnt; f0 = ferr_cnt;
    send_frame(8'h96, 1'b1, 83);
    cycles(20);
    chk("baud_data", 32'(uart_data), 32'h96);
    chk("baud_strobes", 32'(rcv_cnt - r0), 32'd1);
    chk("baud_ferr", 32'(ferr_cnt - f0), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
